// File: rtl/self_pkg.sv
// Shared types and helpers for the SELF arbitrated elastic buffer.
package self_pkg;

  typedef enum logic [1:0] {
    EB_EMPTY = 2'd0,
    EB_HALF  = 2'd1,
    EB_FULL  = 2'd2
  } eb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/self_rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
module self_rr_pick
  import self_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            any,
  output logic [IDXW-1:0] win
);

  always_comb begin : scan
    logic [IDXW-1:0] idx;
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDXW'((int'(ptr) + i) % NREQ);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/self_arb_eb.sv
// Round-robin arbiter feeding a 2-slot SELF elastic buffer (main/aux registers).
// Optional source lock with `define SELF_ARB_LOCK_EN (adds lock_i port).
module self_arb_eb
  import self_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDXW  = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       valid_i,
  input  logic [NREQ*WIDTH-1:0] data_i,
  output logic [NREQ-1:0]       stop_o,
  output logic                  valid_o,
  output logic [WIDTH-1:0]      data_o,
  output logic [IDXW-1:0]       src_o,
  input  logic                  stop_i
`ifdef SELF_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]       lock_i
`endif
);

  eb_state_t        state_reg, state_next;
  logic [IDXW-1:0]  rr_ptr_reg;
  logic [WIDTH-1:0] main_data_reg, aux_data_reg;
  logic [IDXW-1:0]  main_src_reg, aux_src_reg;
  logic [NREQ-1:0]  req_elig;
  logic             any, full, push, pop;
  logic [IDXW-1:0]  win;
  logic [WIDTH-1:0] win_data;

`ifdef SELF_ARB_LOCK_EN
  logic            locked_reg;
  logic [IDXW-1:0] lock_idx_reg;

  // While locked only the owner is eligible, even when it is idle.
  always_comb begin
    req_elig = valid_i;
    if (locked_reg) req_elig = valid_i & (NREQ'(1) << lock_idx_reg);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_reg   <= 1'b0;
      lock_idx_reg <= '0;
    end else if (push) begin
      locked_reg   <= lock_i[win];
      lock_idx_reg <= win;
    end
  end
`else
  assign req_elig = valid_i;
`endif

  self_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req (req_elig),
    .ptr (rr_ptr_reg),
    .any (any),
    .win (win)
  );

  assign win_data = data_i[int'(win)*WIDTH +: WIDTH];
  assign push     = any & ~full & ~reset;
  assign pop      = valid_o & ~stop_i;

  // Reset forces all stops high combinationally so nothing is taken during reset.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stop
    assign stop_o[gi] = reset | ~any | full | (win != IDXW'(gi));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= EB_EMPTY;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EB_EMPTY: if (push) state_next = EB_HALF;
      EB_HALF: begin
        if (push && !pop)      state_next = EB_FULL;
        else if (pop && !push) state_next = EB_EMPTY;
      end
      EB_FULL:  if (pop) state_next = EB_HALF;
      default:  state_next = EB_EMPTY;
    endcase
  end

  always_comb begin
    valid_o = (state_reg != EB_EMPTY);
    full    = (state_reg == EB_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data_reg <= '0;
      main_src_reg  <= '0;
      aux_data_reg  <= '0;
      aux_src_reg   <= '0;
    end else begin
      case (state_reg)
        EB_EMPTY: begin
          if (push) begin
            main_data_reg <= win_data;
            main_src_reg  <= win;
          end
        end
        EB_HALF: begin
          if (push && pop) begin
            main_data_reg <= win_data;
            main_src_reg  <= win;
          end else if (push) begin
            aux_data_reg <= win_data;
            aux_src_reg  <= win;
          end
        end
        EB_FULL: begin
          if (pop) begin
            main_data_reg <= aux_data_reg;
            main_src_reg  <= aux_src_reg;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     rr_ptr_reg <= '0;
    else if (push) rr_ptr_reg <= (win == IDXW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  assign data_o = main_data_reg;
  assign src_o  = main_src_reg;

endmodule
